// File: rtl/test_monitor.sv
// End-of-test monitor: watches one core's register-file writeback for the
// done/result/testnum convention and reports pass, fail or timeout.
module test_monitor #(
  parameter int          NUM_CORES      = 2,
  parameter int          XLEN           = 32,
  parameter int          DONE_REG       = 26,
  parameter int          RESULT_REG     = 27,
  parameter int          TESTNUM_REG    = 3,
  parameter int          SETTLE_CYCLES  = 5,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [31:0] INV_MASK       = 32'b10,
  localparam int         CW             = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [CW-1:0]            core_sel_i,
  input  logic [NUM_CORES-1:0]     we_i,
  input  logic [NUM_CORES*5-1:0]   waddr_i,
  input  logic [NUM_CORES*XLEN-1:0] wdata_i,
  output logic                     busy_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [XLEN-1:0]          fail_testnum_o,
  output logic [31:0]              cycle_cnt_o
);

  typedef enum logic [2:0] {IDLE, ARMED, SETTLE, PASS, FAIL, TIMEOUT} state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_VAL = 32'(TIMEOUT_CYCLES);

  state_t          state;
  logic [CW-1:0]   sel;
  logic [XLEN-1:0] result_sh;
  logic [XLEN-1:0] testnum_sh;
  logic [7:0]      settle_cnt;

  logic [XLEN-1:0] core_data [NUM_CORES];
  logic [4:0]      core_addr [NUM_CORES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign core_addr[gi] = waddr_i[5*gi +: 5];
      assign core_data[gi] = INV_MASK[gi] ? ~wdata_i[XLEN*gi +: XLEN]
                                          :  wdata_i[XLEN*gi +: XLEN];
    end
  endgenerate

  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [XLEN-1:0] wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (sel == CW'(k)) begin
        wr_en   = we_i[k];
        wr_addr = core_addr[k];
        wr_data = core_data[k];
      end
    end
  end

  logic            wr_qual;
  logic            done_hit;
  logic [XLEN-1:0] result_next;
  logic [XLEN-1:0] testnum_next;
  logic [31:0]     cnt_inc;
  logic [CW-1:0]   sel_next;

  assign wr_qual      = wr_en && (wr_addr != 5'd0) && (state == ARMED || state == SETTLE);
  assign result_next  = (wr_qual && wr_addr == 5'(RESULT_REG))  ? wr_data : result_sh;
  assign testnum_next = (wr_qual && wr_addr == 5'(TESTNUM_REG)) ? wr_data : testnum_sh;
  assign done_hit     = wr_qual && (state == ARMED) && (wr_addr == 5'(DONE_REG))
                        && (wr_data == XLEN'(1));
  assign cnt_inc      = (cycle_cnt_o == 32'hFFFF_FFFF) ? cycle_cnt_o : cycle_cnt_o + 32'd1;
  assign sel_next     = (32'(core_sel_i) < 32'(NUM_CORES)) ? core_sel_i : '0;

  // Verdicts use the *_next shadows so a write on the deciding edge still counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      sel            <= '0;
      result_sh      <= '0;
      testnum_sh     <= '0;
      settle_cnt     <= '0;
      busy_o         <= 1'b0;
      pass_o         <= 1'b0;
      fail_o         <= 1'b0;
      timeout_o      <= 1'b0;
      fail_testnum_o <= '0;
      cycle_cnt_o    <= '0;
    end else if (start_i) begin
      state          <= ARMED;
      sel            <= sel_next;
      result_sh      <= '0;
      testnum_sh     <= '0;
      settle_cnt     <= '0;
      busy_o         <= 1'b1;
      pass_o         <= 1'b0;
      fail_o         <= 1'b0;
      timeout_o      <= 1'b0;
      fail_testnum_o <= '0;
      cycle_cnt_o    <= '0;
    end else begin
      case (state)
        ARMED: begin
          result_sh   <= result_next;
          testnum_sh  <= testnum_next;
          cycle_cnt_o <= cnt_inc;
          if (done_hit) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end else if (cnt_inc == TIMEOUT_VAL) begin
            state          <= TIMEOUT;
            busy_o         <= 1'b0;
            timeout_o      <= 1'b1;
            fail_testnum_o <= testnum_next;
          end
        end
        SETTLE: begin
          result_sh  <= result_next;
          testnum_sh <= testnum_next;
          if (settle_cnt == SETTLE_LAST) begin
            busy_o <= 1'b0;
            if (result_next == XLEN'(1)) begin
              state  <= PASS;
              pass_o <= 1'b1;
            end else begin
              state          <= FAIL;
              fail_o         <= 1'b1;
              fail_testnum_o <= testnum_next;
            end
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
